// File: rtl/nts_dispatch_fifo.sv
// Packet-granular receive FIFO: commits only complete, good frames that fit and
// streams them out per frame. Optional counters via NTS_DISPATCH_STATS_EN.
module nts_dispatch_fifo #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned PKT_WIDTH  = 3
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_rx_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_last,
    input  logic        i_rx_bad_frame,
    output logic        o_dispatch_packet_available,
    input  logic        i_dispatch_packet_read,
    output logic        o_dispatch_fifo_empty,
    input  logic        i_dispatch_fifo_rd_start,
    output logic        o_dispatch_fifo_rd_valid,
    output logic [63:0] o_dispatch_fifo_rd_data
`ifdef NTS_DISPATCH_STATS_EN
    ,
    output logic [31:0] o_stat_accepted,
    output logic [31:0] o_stat_dropped_bad,
    output logic [31:0] o_stat_dropped_full
`endif
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned CW    = PKT_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PKTS  = 1 << PKT_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_WAIT_ACK} rstate_e;

    logic [63:0]           mem [DEPTH];
    logic [PW-1:0]         lf_mem [PKTS];

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         frame_start_q, frame_start_d;
    logic [PW-1:0]         len_q, len_d;
    logic [PW-1:0]         head_ptr_q, head_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_valid_q;
    logic [63:0]           rd_data_q;
    logic [PKT_WIDTH-1:0]  lf_wr_ptr_q, lf_rd_ptr_q;
    logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic                  avail_q, avail_d;
    logic                  empty_q, empty_d;

    logic [PW-1:0]         used_c;
    logic [PW-1:0]         head_len_c;
    logic [PW-1:0]         commit_len_c;
    logic                  ram_full_c, lf_full_c;
    logic                  ram_we_c, commit_c, pop_c;

    assign used_c     = wr_ptr_q - head_ptr_q;
    assign ram_full_c = (used_c == PW'(DEPTH));
    assign lf_full_c  = (pkt_cnt_q == CW'(PKTS));
    assign head_len_c = lf_mem[lf_rd_ptr_q];

    // Write FSM: a frame is written speculatively and rolled back unless it commits.
    always_comb begin
        wstate_d      = wstate_q;
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        len_d         = len_q;
        ram_we_c      = 1'b0;
        commit_c      = 1'b0;
        commit_len_c  = '0;
        case (wstate_q)
            W_IDLE: begin
                if (i_rx_valid) begin
                    if (lf_full_c || ram_full_c) begin
                        if (!i_rx_last) wstate_d = W_DROP;
                    end else if (i_rx_last) begin
                        if (!i_rx_bad_frame) begin
                            ram_we_c     = 1'b1;
                            wr_ptr_d     = wr_ptr_q + PW'(1);
                            commit_c     = 1'b1;
                            commit_len_c = PW'(1);
                        end
                    end else begin
                        ram_we_c      = 1'b1;
                        frame_start_d = wr_ptr_q;
                        wr_ptr_d      = wr_ptr_q + PW'(1);
                        len_d         = PW'(1);
                        wstate_d      = W_RECV;
                    end
                end
            end
            W_RECV: begin
                if (i_rx_valid) begin
                    if (ram_full_c) begin
                        wr_ptr_d = frame_start_q;
                        wstate_d = i_rx_last ? W_IDLE : W_DROP;
                    end else if (i_rx_last) begin
                        wstate_d = W_IDLE;
                        if (i_rx_bad_frame) begin
                            wr_ptr_d = frame_start_q;
                        end else begin
                            ram_we_c     = 1'b1;
                            wr_ptr_d     = wr_ptr_q + PW'(1);
                            commit_c     = 1'b1;
                            commit_len_c = len_q + PW'(1);
                        end
                    end else begin
                        ram_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        len_d    = len_q + PW'(1);
                    end
                end
            end
            W_DROP: begin
                if (i_rx_valid && i_rx_last) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read FSM plus frame bookkeeping shared with the write side.
    always_comb begin
        rstate_d    = rstate_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        rd_en_d     = 1'b0;
        pop_c       = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (i_dispatch_fifo_rd_start && avail_q) begin
                    remaining_d = head_len_c;
                    rd_ptr_d    = head_ptr_q;
                    rstate_d    = R_STREAM;
                end
            end
            R_STREAM: begin
                rd_en_d     = 1'b1;
                rd_ptr_d    = rd_ptr_q + PW'(1);
                remaining_d = remaining_q - PW'(1);
                if (remaining_q == PW'(1)) rstate_d = R_WAIT_ACK;
            end
            R_WAIT_ACK: begin
                if (i_dispatch_packet_read) begin
                    pop_c    = 1'b1;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        head_ptr_d = pop_c ? (head_ptr_q + head_len_c) : head_ptr_q;
        case ({commit_c, pop_c})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        avail_d = (pkt_cnt_d != '0);
        // Stays low while words are still in the read pipeline.
        empty_d = !(((rstate_d == R_IDLE) && avail_d) || (rstate_d == R_STREAM) ||
                    rd_en_d || rd_en_q);
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wstate_q      <= W_IDLE;
            rstate_q      <= R_IDLE;
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            len_q         <= '0;
            head_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            remaining_q   <= '0;
            rd_addr_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            lf_wr_ptr_q   <= '0;
            lf_rd_ptr_q   <= '0;
            pkt_cnt_q     <= '0;
            avail_q       <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            wstate_q      <= wstate_d;
            rstate_q      <= rstate_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            len_q         <= len_d;
            head_ptr_q    <= head_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            remaining_q   <= remaining_d;
            rd_en_q       <= rd_en_d;
            rd_valid_q    <= rd_en_q;
            if (rd_en_d) rd_addr_q <= rd_ptr_q[ADDR_WIDTH-1:0];
            if (rd_en_q) rd_data_q <= mem[rd_addr_q];
            if (commit_c) lf_wr_ptr_q <= lf_wr_ptr_q + PKT_WIDTH'(1);
            if (pop_c) lf_rd_ptr_q <= lf_rd_ptr_q + PKT_WIDTH'(1);
            pkt_cnt_q     <= pkt_cnt_d;
            avail_q       <= avail_d;
            empty_q       <= empty_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we_c) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_rx_data;
        if (commit_c) lf_mem[lf_wr_ptr_q] <= commit_len_c;
    end

    assign o_dispatch_packet_available = avail_q;
    assign o_dispatch_fifo_empty       = empty_q;
    assign o_dispatch_fifo_rd_valid    = rd_valid_q;
    assign o_dispatch_fifo_rd_data     = rd_data_q;

`ifdef NTS_DISPATCH_STATS_EN
    logic [31:0] stat_acc_q, stat_bad_q, stat_full_q;
    logic        stat_bad_c, stat_full_c;

    assign stat_full_c = i_rx_valid &&
        (((wstate_q == W_IDLE) && (lf_full_c || ram_full_c)) ||
         ((wstate_q == W_RECV) && ram_full_c));
    assign stat_bad_c  = i_rx_valid && i_rx_last && i_rx_bad_frame &&
        (((wstate_q == W_IDLE) && !lf_full_c && !ram_full_c) ||
         ((wstate_q == W_RECV) && !ram_full_c));

    // Saturating event counters.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            stat_acc_q  <= '0;
            stat_bad_q  <= '0;
            stat_full_q <= '0;
        end else begin
            if (commit_c && (stat_acc_q != '1)) stat_acc_q <= stat_acc_q + 32'd1;
            if (stat_bad_c && (stat_bad_q != '1)) stat_bad_q <= stat_bad_q + 32'd1;
            if (stat_full_c && (stat_full_q != '1)) stat_full_q <= stat_full_q + 32'd1;
        end
    end

    assign o_stat_accepted     = stat_acc_q;
    assign o_stat_dropped_bad  = stat_bad_q;
    assign o_stat_dropped_full = stat_full_q;
`endif

endmodule

// File: tb/tb_nts_dispatch_fifo.sv
// Directed scoreboard bench for nts_dispatch_fifo (16-word RAM, 8-frame queue).
module tb_nts_dispatch_fifo;

    localparam int DEPTH = 16;
    localparam int PKTS  = 8;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        rx_valid, rx_last, rx_bad;
    logic [63:0] rx_data;
    logic        avail, pkt_read, empty, rd_start, rd_valid;
    logic [63:0] rd_data;
`ifdef NTS_DISPATCH_STATS_EN
    logic [31:0] st_acc, st_bad, st_full;
`endif

    int checks = 0;
    int errors = 0;
    int model_used = 0;
    int model_pkts = 0;
    int pending_len = 0;
    logic [63:0] frame_q[$];
    logic [63:0] exp_q[$];
    int          exp_len_q[$];

    nts_dispatch_fifo #(.ADDR_WIDTH(4), .PKT_WIDTH(3)) dut (
        .i_clk                       (clk),
        .i_areset_n                  (areset_n),
        .i_rx_valid                  (rx_valid),
        .i_rx_data                   (rx_data),
        .i_rx_last                   (rx_last),
        .i_rx_bad_frame              (rx_bad),
        .o_dispatch_packet_available (avail),
        .i_dispatch_packet_read      (pkt_read),
        .o_dispatch_fifo_empty       (empty),
        .i_dispatch_fifo_rd_start    (rd_start),
        .o_dispatch_fifo_rd_valid    (rd_valid),
        .o_dispatch_fifo_rd_data     (rd_data)
`ifdef NTS_DISPATCH_STATS_EN
        ,
        .o_stat_accepted             (st_acc),
        .o_stat_dropped_bad          (st_bad),
        .o_stat_dropped_full         (st_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sends frame_q; the model decides whether the frame should commit.
    task automatic send_frame(input bit bad, input bit ack_last);
        int  n;
        bit  commit;
        n = frame_q.size();
        commit = !bad && (n <= DEPTH - model_used) && (model_pkts < PKTS);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = frame_q[i];
            rx_last  = (i == n - 1);
            rx_bad   = bad && (i == n - 1);
            if (ack_last && (i == n - 1)) pkt_read = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_bad   = 1'b0;
        pkt_read = 1'b0;
        if (commit) begin
            foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
            exp_len_q.push_back(n);
            model_used += n;
            model_pkts++;
        end
        if (ack_last) begin
            model_pkts--;
            model_used -= pending_len;
        end
        frame_q.delete();
        chk("avail_after_frame", 64'(avail), 64'(model_pkts != 0));
    endtask

    task automatic stream_frame();
        logic [63:0] last_word;
        pending_len = exp_len_q.pop_front();
        last_word = '0;
        chk("avail_before_read", 64'(avail), 64'd1);
        chk("empty_before_read", 64'(empty), 64'd0);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        chk("first_word_latency", 64'(rd_valid), 64'd0);
        for (int i = 0; i < pending_len; i++) begin
            step();
            last_word = exp_q.pop_front();
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_data", rd_data, last_word);
            if (i == pending_len - 1) chk("empty_on_last", 64'(empty), 64'd0);
        end
        step();
        chk("rd_valid_done", 64'(rd_valid), 64'd0);
        chk("empty_after_stream", 64'(empty), 64'd1);
        chk("rd_data_hold", rd_data, last_word);
    endtask

    task automatic ack_frame();
        pkt_read = 1'b1;
        step();
        pkt_read = 1'b0;
        model_pkts--;
        model_used -= pending_len;
        chk("avail_after_ack", 64'(avail), 64'(model_pkts != 0));
        chk("empty_after_ack", 64'(empty), 64'(model_pkts == 0));
    endtask

    initial begin
        areset_n = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_last  = 1'b0;
        rx_bad   = 1'b0;
        pkt_read = 1'b0;
        rd_start = 1'b0;
        step();
        step();
        chk("reset_avail", 64'(avail), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        areset_n = 1'b1;
        step();

        // Basic 3-word frame
        frame_q.push_back(64'hdeadbeef00000000);
        frame_q.push_back(64'habad1deac0fef00d);
        frame_q.push_back(64'h0123456789abcdef);
        send_frame(1'b0, 1'b0);
        stream_frame();
        ack_frame();

        // Bad frame discarded, then a single-word frame
        for (int i = 0; i < 4; i++) frame_q.push_back(64'hbad0000000000000 + 64'(i));
        send_frame(1'b1, 1'b0);
        frame_q.push_back(64'h1122334455667788);
        send_frame(1'b0, 1'b0);
        stream_frame();
        ack_frame();

        // Oversized frame dropped, exact-fit frame kept
        for (int i = 0; i < 20; i++) frame_q.push_back(64'ha000000000000000 + 64'(i));
        send_frame(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) frame_q.push_back(64'hc0de000000000000 + 64'(i));
        send_frame(1'b0, 1'b0);
        stream_frame();
        ack_frame();

        // Length queue overflow: ninth frame dropped
        for (int f = 0; f < 9; f++) begin
            frame_q.push_back(64'h1000000000000000 + 64'(f));
            send_frame(1'b0, 1'b0);
        end
        for (int f = 0; f < 8; f++) begin
            stream_frame();
            ack_frame();
        end

        // Commit of B coincides with release of A
        frame_q.push_back(64'haaaa000000000001);
        frame_q.push_back(64'haaaa000000000002);
        send_frame(1'b0, 1'b0);
        stream_frame();
        frame_q.push_back(64'hbbbb000000000001);
        frame_q.push_back(64'hbbbb000000000002);
        frame_q.push_back(64'hbbbb000000000003);
        send_frame(1'b0, 1'b1);
        stream_frame();
        ack_frame();

        // Read start with nothing queued
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_rd_valid", 64'(rd_valid), 64'd0);
            chk("idle_empty", 64'(empty), 64'd1);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) frame_q.push_back(64'hfeed000000000000 + 64'(i));
        send_frame(1'b0, 1'b0);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        chk("pre_reset_rd_valid", 64'(rd_valid), 64'd1);
        #1 areset_n = 1'b0;
        #1;
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("async_rst_avail", 64'(avail), 64'd0);
        chk("async_rst_empty", 64'(empty), 64'd1);
        #1 areset_n = 1'b1;
        exp_q.delete();
        exp_len_q.delete();
        model_used = 0;
        model_pkts = 0;
        step();
        chk("post_reset_avail", 64'(avail), 64'd0);

        // Normal operation after reset
        frame_q.push_back(64'h5555aaaa5555aaaa);
        send_frame(1'b0, 1'b0);
        stream_frame();
        ack_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
